loop_index_engine: RTL and testbench
====================================

LOOP_INDEX_ENGINE -- requirements
Module: loop_index_engine

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of every index, limit, stride and address.
REQ-002 Parameter: LEVELS, default 3, number of nested loop levels; level 0 is innermost; legal range 1..8.
REQ-003 Port: Clk  input  1  single system clock, rising-edge active.
REQ-004 Port: Rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 Port: limit  input  LEVELS*WIDTH  per-level trip count; level l occupies bits [l*WIDTH +: WIDTH].
REQ-007 Port: stride  input  LEVELS*WIDTH  per-level address stride, packed as for limit.
REQ-008 Port: base  input  WIDTH  base address of the sweep.
REQ-009 Port: advance  input  1  consumer accepts the current tuple; effective only while valid=1.
REQ-010 Port: abort  input  1  terminate the sweep early (see Configuration).
REQ-011 Port: idx  output  LEVELS*WIDTH  current index per level, packed as for limit.
REQ-012 Port: addr  output  WIDTH  current linear address.
REQ-013 Port: last  output  LEVELS  bit l = idx[l] equals limit[l]-1, qualified by valid.
REQ-014 Port: valid  output  1  idx/addr/last hold a live tuple.
REQ-015 Port: busy  output  1  high in RUN and DONE.
REQ-016 Port: done  output  1  one-cycle pulse at sweep completion.

Function
REQ-017 FSM states: IDLE, RUN, DONE; no other states are reachable.
REQ-018 IDLE + start=1: latch limit, stride and base into internal registers; clear all idx; go to RUN, or to DONE if any latched limit equals 0.
REQ-019 Inputs limit/stride/base are ignored outside the start-accept edge; changes mid-sweep have no effect.
REQ-020 RUN: valid=1; addr = base + sum over l of idx[l]*stride[l], modulo 2^WIDTH, updated combinationally or registered but exact in every cycle valid=1.
REQ-021 RUN + advance=1: level 0 increments; a level at limit-1 wraps to 0 and carries into the next level; one tuple consumed per accepting edge.
REQ-022 RUN + advance=1 with all last bits set: go to DONE; valid=0 from the next cycle; idx cleared to 0.
REQ-023 RUN + advance=0: idx, addr and valid hold (stall).
REQ-024 DONE: done=1 for exactly one cycle, valid=0; next state IDLE unconditionally.
REQ-025 start in RUN or DONE is ignored; no restart, no queueing.
REQ-026 Address arithmetic wraps modulo 2^WIDTH without error indication.
REQ-027 Total tuples emitted per sweep = product of latched limits; 0 if any limit is 0.

Reset
REQ-028 Rst_n=0 asynchronously forces IDLE, idx=0, addr=0, last=0, valid=0, busy=0, done=0, and clears latched registers; this applies mid-sweep.
REQ-029 First sweep after reset release requires a fresh start.

Configuration
REQ-030 Macro LOOP_INDEX_ABORT_EN defined: abort=1 in RUN sends the FSM to IDLE on the next edge without a done pulse, with idx cleared and valid=0; abort has priority over advance on the same edge; abort is ignored in IDLE and DONE.
REQ-031 Macro LOOP_INDEX_ABORT_EN undefined: the abort port is present but ignored, and sweeps end only via completion or reset.

Verification
REQ-032 LEVELS=3, limit={2,3,4} (lvl2,1,0), stride={12,4,1}, base=0x10, advance held 1 -> 24 tuples, addr 0x10..0x27 consecutive, done one cycle after the 24th accept.
REQ-033 Same setup, advance toggled 1/0 each cycle -> identical tuple sequence, stalled cycles hold idx/addr, done after 48 cycles of RUN.
REQ-034 limit lvl1=0, others nonzero, start -> valid never high, done pulses within 2 cycles of start.
REQ-035 base=0xF0, limit lvl0=32, stride lvl0=1 -> addr wraps 0xFF to 0x00 at the 16th tuple, with no other effect.
REQ-036 Rst_n pulsed low at tuple 5 -> outputs zero immediately; start after release restarts at idx=0, addr=base.
REQ-037 With LOOP_INDEX_ABORT_EN, abort=1 and advance=1 at tuple 3 -> IDLE next cycle, no done pulse; without the macro, the sweep completes normally.

Source files
------------

// File: rtl/loop_index_engine.sv
// loop_index_engine: nested-loop index/address sequencer with a valid/advance handshake.
// Define LOOP_INDEX_ABORT_EN to let abort end a running sweep early.
module loop_index_engine #(
  parameter int WIDTH  = 8,
  parameter int LEVELS = 3
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    start,
  input  logic [LEVELS*WIDTH-1:0] limit,
  input  logic [LEVELS*WIDTH-1:0] stride,
  input  logic [WIDTH-1:0]        base,
  input  logic                    advance,
  input  logic                    abort,
  output logic [LEVELS*WIDTH-1:0] idx,
  output logic [WIDTH-1:0]        addr,
  output logic [LEVELS-1:0]       last,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [WIDTH-1:0]  lim [LEVELS];
  logic [WIDTH-1:0]  str [LEVELS];
  logic [WIDTH-1:0]  cur [LEVELS];
  logic [WIDTH-1:0]  nxt [LEVELS];
  logic [WIDTH-1:0]  bas;
  logic [WIDTH-1:0]  sum;
  logic [LEVELS-1:0] at_end;
  logic              wrap_all;
  logic              any_zero;
  logic              kill;
`ifdef LOOP_INDEX_ABORT_EN
  assign kill = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign kill = 1'b0;
`endif
  always_comb begin
    any_zero = 1'b0;
    for (int l = 0; l < LEVELS; l++) any_zero = any_zero | (limit[l*WIDTH +: WIDTH] == '0);
  end
  // Ripple carry: wrap_all survives only while every lower level sits at its last index.
  always_comb begin
    wrap_all = 1'b1;
    at_end = '0;
    for (int l = 0; l < LEVELS; l++) begin
      at_end[l] = cur[l] == lim[l] - WIDTH'(1);
      nxt[l] = wrap_all ? (at_end[l] ? '0 : cur[l] + WIDTH'(1)) : cur[l];
      wrap_all = wrap_all & at_end[l];
    end
  end
  always_comb begin
    sum = bas;
    idx = '0;
    for (int l = 0; l < LEVELS; l++) begin
      sum = sum + cur[l] * str[l];
      idx[l*WIDTH +: WIDTH] = cur[l];
    end
    addr = valid ? sum : '0;
    last = valid ? at_end : '0;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bas   <= '0;
      for (int l = 0; l < LEVELS; l++) begin
        lim[l] <= '0;
        str[l] <= '0;
        cur[l] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int l = 0; l < LEVELS; l++) begin
              lim[l] <= limit[l*WIDTH +: WIDTH];
              str[l] <= stride[l*WIDTH +: WIDTH];
              cur[l] <= '0;
            end
            bas   <= base;
            busy  <= 1'b1;
            state <= any_zero ? DONE : RUN;
            done  <= any_zero;
            valid <= !any_zero;
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            for (int l = 0; l < LEVELS; l++) cur[l] <= '0;
          end else if (advance) begin
            for (int l = 0; l < LEVELS; l++) cur[l] <= nxt[l];
            if (wrap_all) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_loop_index_engine.sv
// tb_loop_index_engine: directed self-checking bench for loop_index_engine.
module tb_loop_index_engine;
  localparam int W = 8;
  localparam int L = 3;
  logic           Clk = 1'b0;
  logic           Rst_n = 1'b0;
  logic           start = 1'b0;
  logic           advance = 1'b0;
  logic           abort = 1'b0;
  logic [L*W-1:0] limit = '0;
  logic [L*W-1:0] stride = '0;
  logic [W-1:0]   base = '0;
  logic [L*W-1:0] idx;
  logic [W-1:0]   addr;
  logic [L-1:0]   last;
  logic           valid, busy, done;
  int n_pass = 0;
  int n_chk = 0;

  always #5 Clk = ~Clk;

  loop_index_engine #(.WIDTH(W), .LEVELS(L)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .limit(limit), .stride(stride),
    .base(base), .advance(advance), .abort(abort), .idx(idx), .addr(addr),
    .last(last), .valid(valid), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [23:0] tup_idx(input int k);
    tup_idx = {8'(k / 12), 8'((k / 4) % 3), 8'(k % 4)};
  endfunction

  function automatic logic [2:0] tup_last(input int k);
    tup_last = {k / 12 == 1, (k / 4) % 3 == 2, k % 4 == 3};
  endfunction

  task automatic setup_a();
    limit  = {8'd2, 8'd3, 8'd4};
    stride = {8'd12, 8'd4, 8'd1};
    base   = 8'h10;
  endtask

  // After the accept edge the inputs are scrambled; the latched copies must win.
  task automatic launch();
    start = 1'b1;
    step();
    start  = 1'b0;
    limit  = '1;
    stride = '1;
    base   = '1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_idx"}, 32'(idx), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_last"}, 32'(last), 32'd0);
  endtask

  initial begin
    #12;
    check_idle("rst");
    step();
    Rst_n = 1'b1;
    step();
    check_idle("post_rst");

    // Full sweep, advance held high.
    setup_a();
    launch();
    advance = 1'b1;
    for (int k = 0; k < 24; k++) begin
      check("a_idx", 32'(idx), 32'(tup_idx(k)));
      check("a_addr", 32'(addr), 32'(16 + k));
      check("a_last", 32'(last), 32'(tup_last(k)));
      check("a_valid", 32'(valid), 32'd1);
      step();
    end
    check("a_done", 32'(done), 32'd1);
    check("a_valid_end", 32'(valid), 32'd0);
    check("a_busy_done", 32'(busy), 32'd1);
    check("a_idx_clr", 32'(idx), 32'd0);
    step();
    check("a_done_once", 32'(done), 32'd0);
    check("a_busy_idle", 32'(busy), 32'd0);

    // Same sweep with advance toggling; stalled cycles must hold.
    setup_a();
    launch();
    for (int k = 0; k < 24; k++) begin
      advance = 1'b0;
      check("b_idx", 32'(idx), 32'(tup_idx(k)));
      step();
      check("b_stall_idx", 32'(idx), 32'(tup_idx(k)));
      check("b_stall_addr", 32'(addr), 32'(16 + k));
      check("b_stall_valid", 32'(valid), 32'd1);
      advance = 1'b1;
      step();
    end
    advance = 1'b0;
    check("b_done", 32'(done), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("b_start_in_done_busy", 32'(busy), 32'd0);
    check("b_start_in_done_valid", 32'(valid), 32'd0);
    step();
    check("b_no_restart", 32'(busy), 32'd0);

    // Zero trip count on level 1.
    limit  = {8'd2, 8'd0, 8'd4};
    stride = {8'd12, 8'd4, 8'd1};
    base   = 8'h10;
    launch();
    check("c_valid", 32'(valid), 32'd0);
    check("c_done", 32'(done), 32'd1);
    check("c_busy", 32'(busy), 32'd1);
    step();
    check("c_valid2", 32'(valid), 32'd0);
    check("c_done2", 32'(done), 32'd0);
    check("c_busy2", 32'(busy), 32'd0);

    // Address wrap past 0xFF.
    limit  = {8'd1, 8'd1, 8'd32};
    stride = {8'd0, 8'd0, 8'd1};
    base   = 8'hF0;
    launch();
    advance = 1'b1;
    for (int k = 0; k < 32; k++) begin
      check("d_addr", 32'(addr), 32'((240 + k) % 256));
      check("d_idx", 32'(idx), 32'(k));
      step();
    end
    advance = 1'b0;
    check("d_done", 32'(done), 32'd1);
    step();

    // Asynchronous reset mid-sweep.
    setup_a();
    launch();
    advance = 1'b1;
    repeat (5) step();
    advance = 1'b0;
    check("e_idx5", 32'(idx), 32'(tup_idx(5)));
    check("e_addr5", 32'(addr), 32'h15);
    #2;
    Rst_n = 1'b0;
    #1;
    check_idle("e_async");
    step();
    Rst_n = 1'b1;
    step();
    step();
    check_idle("e_needs_start");
    setup_a();
    launch();
    check("e_restart_idx", 32'(idx), 32'd0);
    check("e_restart_addr", 32'(addr), 32'h10);
    check("e_restart_valid", 32'(valid), 32'd1);
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    step();

    // Abort together with advance at tuple 3.
    setup_a();
    launch();
    advance = 1'b1;
    repeat (3) step();
    check("f_idx3", 32'(idx), 32'(tup_idx(3)));
    abort = 1'b1;
    step();
    abort = 1'b0;
`ifdef LOOP_INDEX_ABORT_EN
    advance = 1'b0;
    check_idle("f_abort");
    step();
    check("f_no_done", 32'(done), 32'd0);
    check("f_stay_idle", 32'(busy), 32'd0);
`else
    check("f_idx4", 32'(idx), 32'(tup_idx(4)));
    check("f_valid", 32'(valid), 32'd1);
    repeat (20) step();
    advance = 1'b0;
    check("f_done", 32'(done), 32'd1);
    step();
    check("f_idle", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
